// File: rtl/adc_snap_sched_pkg.sv
// Shared types and constants for the ADC snapshot capture scheduler.
package adc_snap_pkg;
  localparam int DATA_W = 128;
  localparam int CHAN_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SYNC,
    S_CAPTURE,
    S_DONE
  } state_t;
endpackage

// File: rtl/adc_snap_sched_if.sv
// Request, ADC stream and capture-buffer signals of the snapshot scheduler.
interface adc_snap_sched_if
  import adc_snap_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NCHAN = 8,
  parameter int LEN_W = 10
) ();
  logic [NREQ-1:0]         req;
  logic [NREQ*CHAN_W-1:0]  req_chan;
  logic [NREQ*LEN_W-1:0]   req_len;
  logic [NREQ-1:0]         req_sync;
  logic                    abort;
  logic [NCHAN*DATA_W-1:0] adc_tdata;
  logic [NCHAN-1:0]        adc_tvalid;
  logic                    sysref_i;
  logic [NREQ-1:0]         grant;
  logic [NREQ-1:0]         done;
  logic                    aborted;
  logic                    busy;
  logic                    buf_wr_en;
  logic [LEN_W-1:0]        buf_wr_addr;
  logic [DATA_W-1:0]       buf_wr_data;

  modport master (
    output req, req_chan, req_len, req_sync, abort, adc_tdata, adc_tvalid, sysref_i,
    input  grant, done, aborted, busy, buf_wr_en, buf_wr_addr, buf_wr_data
  );

  modport slave (
    input  req, req_chan, req_len, req_sync, abort, adc_tdata, adc_tvalid, sysref_i,
    output grant, done, aborted, busy, buf_wr_en, buf_wr_addr, buf_wr_data
  );
endinterface

// File: rtl/adc_snap_sched_rr_arbiter.sv
// Round-robin arbiter: searches upward from the slot after the last winner.
module rr_arbiter #(
  parameter int  NREQ  = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [NREQ-1:0]  i_req,
  output logic [NREQ-1:0]  o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);
  logic [IDX_W-1:0] r_ptr;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_valid && i_req[(int'(r_ptr) + k) % NREQ]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'((int'(r_ptr) + k) % NREQ);
      end
    end
    o_grant = o_valid ? (NREQ'(1) << o_idx) : '0;
  end

  // The pointer only moves when the scheduler actually accepts the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_en && o_valid) begin
      r_ptr <= (int'(o_idx) == NREQ - 1) ? '0 : o_idx + 1'b1;
    end
  end
endmodule

// File: rtl/adc_snap_sched.sv
// Snapshot scheduler: arbitrates capture requests and streams one ADC channel
// into the shared capture buffer, optionally aligned to a SYSREF rising edge.
module adc_snap_sched
  import adc_snap_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NCHAN = 8,
  parameter int LEN_W = 10
) (
  input logic aclk,
  input logic aresetn,
  adc_snap_sched_if.slave bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t             r_state;
  logic               r_started;
  logic               r_sysref_d;
  logic [CHAN_W-1:0]  r_chan;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [NREQ-1:0]    r_owner;
  logic [NREQ-1:0]    r_grant;
  logic [NREQ-1:0]    r_done;
  logic               r_aborted;
  logic               r_wr_en;
  logic [LEN_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;

  logic               w_arb_en;
  logic               w_win_valid;
  logic [NREQ-1:0]    w_win_grant;
  logic [IDX_W-1:0]   w_win_idx;
  logic [CHAN_W-1:0]  w_win_chan;
  logic [LEN_W-1:0]   w_win_len;
  logic               w_win_sync;
  logic               w_chan_ok;
  logic               w_beat;
  logic [DATA_W-1:0]  w_beat_data;
  logic               w_sysref_edge;

  // r_started holds off arbitration for one edge after reset release.
  assign w_arb_en = (r_state == S_IDLE) && r_started;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_en    (w_arb_en),
    .i_req   (bus.req),
    .o_grant (w_win_grant),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  assign w_win_chan    = bus.req_chan[int'(w_win_idx)*CHAN_W +: CHAN_W];
  assign w_win_len     = bus.req_len[int'(w_win_idx)*LEN_W +: LEN_W];
  assign w_win_sync    = bus.req_sync[w_win_idx];
  assign w_chan_ok     = int'(r_chan) < NCHAN;
  assign w_beat        = (r_state == S_CAPTURE) && w_chan_ok && bus.adc_tvalid[r_chan];
  assign w_beat_data   = bus.adc_tdata[int'(r_chan)*DATA_W +: DATA_W];
  assign w_sysref_edge = bus.sysref_i && !r_sysref_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= S_IDLE;
      r_started  <= 1'b0;
      r_sysref_d <= 1'b0;
      r_chan     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_owner    <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_aborted  <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_started  <= 1'b1;
      r_sysref_d <= bus.sysref_i;
      r_grant    <= '0;
      r_done     <= '0;
      r_aborted  <= 1'b0;
      r_wr_en    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_arb_en && w_win_valid) begin
            r_grant <= w_win_grant;
            r_owner <= w_win_grant;
            r_chan  <= w_win_chan;
            r_len   <= w_win_len;
            r_cnt   <= '0;
            r_state <= w_win_sync ? S_WAIT_SYNC : S_CAPTURE;
          end
        end
        S_WAIT_SYNC: begin
          if (bus.abort) begin
            r_aborted <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_sysref_edge) begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // A beat sampled together with abort is still written.
          if (w_beat) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_cnt;
            r_wr_data <= w_beat_data;
            r_cnt     <= r_cnt + 1'b1;
          end
          if (bus.abort) begin
            r_aborted <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_beat && (r_cnt == r_len)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= r_owner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.done        = r_done;
  assign bus.aborted     = r_aborted;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.buf_wr_en   = r_wr_en;
  assign bus.buf_wr_addr = r_wr_addr;
  assign bus.buf_wr_data = r_wr_data;
endmodule

// File: tb/tb_adc_snap_sched.sv
// Self-checking bench for adc_snap_sched: expected buffer writes are queued as
// ADC data is driven and matched against the writes the DUT produces.
`timescale 1ns/1ps
module tb_adc_snap_sched;
  import adc_snap_pkg::*;

  localparam int NREQ  = 4;
  localparam int NCHAN = 8;
  localparam int LEN_W = 10;

  typedef struct {
    logic [LEN_W-1:0]  addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_t;

  logic aclk = 1'b0;
  logic aresetn;
  int   nPass  = 0;
  int   nTotal = 0;

  wr_t               expQ[$];
  wr_t               obsQ[$];
  logic [DATA_W-1:0] curData [NCHAN];
  int                doneCyc;
  int                abortedCyc;
  int                lastBeatCyc;
  int                extraGrants;
  logic [NREQ-1:0]   doneVal;
  logic              busyLog [64];

  adc_snap_sched_if #(.NREQ(NREQ), .NCHAN(NCHAN), .LEN_W(LEN_W)) bus ();

  adc_snap_sched #(.NREQ(NREQ), .NCHAN(NCHAN), .LEN_W(LEN_W)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );

  always #5 aclk = ~aclk;

  task automatic driveData();
    for (int k = 0; k < NCHAN; k++) begin
      curData[k] = {$urandom, $urandom, $urandom, $urandom};
      bus.adc_tdata[k*DATA_W +: DATA_W] = curData[k];
    end
  endtask

  task automatic setReq(input int idx, input int chan, input int len, input logic sync);
    bus.req_chan[idx*CHAN_W +: CHAN_W] = CHAN_W'(chan);
    bus.req_len[idx*LEN_W +: LEN_W]    = LEN_W'(len);
    bus.req_sync[idx]                  = sync;
  endtask

  task automatic waitGrant(output logic [NREQ-1:0] g);
    g = '0;
    for (int i = 0; i < 20 && g == '0; i++) begin
      @(negedge aclk);
      g = bus.grant;
    end
  endtask

  task automatic waitIdle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge aclk);
      if (!bus.busy && bus.done == '0) ok = 1'b1;
    end
  endtask

  // Drives one capture window starting at the negedge where grant was seen.
  // Cycle c inputs are sampled at the next posedge; the result shows at c+1.
  task automatic runWindow(input int nCyc, input logic [63:0] validPat, input int chan,
                           input int len, input int sysrefAt, input int abortAt);
    int  beatIdx;
    bit  stopped;
    bit  capturing;
    wr_t w;
    expQ.delete();
    obsQ.delete();
    beatIdx = 0; stopped = 1'b0; capturing = (sysrefAt < 0);
    doneCyc = -1; doneVal = '0; abortedCyc = -1; lastBeatCyc = -1; extraGrants = 0;
    for (int c = 0; c < nCyc; c++) begin
      if (c > 0) @(negedge aclk);
      if (bus.buf_wr_en) begin
        w.addr = bus.buf_wr_addr; w.data = bus.buf_wr_data; w.cyc = c;
        obsQ.push_back(w);
      end
      if (bus.done != '0 && doneCyc < 0) begin doneCyc = c; doneVal = bus.done; end
      if (bus.aborted && abortedCyc < 0) abortedCyc = c;
      if (c > 0 && bus.grant != '0) extraGrants++;
      busyLog[c] = bus.busy;
      driveData();
      bus.adc_tvalid = validPat[c] ? '1 : '0;
      bus.sysref_i   = (sysrefAt >= 0) && (c >= sysrefAt);
      bus.abort      = (c == abortAt);
      if (!capturing && sysrefAt >= 0 && c == sysrefAt + 1) capturing = 1'b1;
      if (capturing && !stopped && validPat[c]) begin
        w.addr = LEN_W'(beatIdx); w.data = curData[chan]; w.cyc = c + 1;
        expQ.push_back(w);
        lastBeatCyc = c;
        beatIdx++;
        if (beatIdx > len) stopped = 1'b1;
      end
      if (c == abortAt) stopped = 1'b1;
    end
    bus.abort = 1'b0; bus.sysref_i = 1'b0; bus.adc_tvalid = '0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    bus.req = '1; bus.abort = 1'b0; bus.sysref_i = 1'b0; bus.adc_tvalid = '1;
    for (int k = 0; k < NREQ; k++) setReq(k, 0, 0, 1'b0);
    driveData();
    repeat (3) @(negedge aclk);
    nTotal++;
    if ({bus.grant, bus.done, bus.aborted, bus.busy, bus.buf_wr_en} !== '0)
      $display("[TB] FAIL reset_ctrl got grant=%b done=%b aborted=%b busy=%b wr_en=%b expected all 0",
               bus.grant, bus.done, bus.aborted, bus.busy, bus.buf_wr_en);
    else nPass++;
    nTotal++;
    if (bus.buf_wr_addr !== '0 || bus.buf_wr_data !== '0)
      $display("[TB] FAIL reset_bus got addr=%0d data=%h expected 0", bus.buf_wr_addr, bus.buf_wr_data);
    else nPass++;
    bus.req = 4'b0001;
    aresetn = 1'b1;
    @(negedge aclk);
    nTotal++;
    if (bus.grant !== '0)
      $display("[TB] FAIL reset_first_edge_grant got %b expected 0000", bus.grant);
    else nPass++;
    bus.req = '0;
    @(negedge aclk);
    nTotal++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL reset_idle_busy got %b expected 0", bus.busy);
    else nPass++;
  endtask

  task automatic test_round_robin();
    int expOrder[5] = '{0, 1, 2, 3, 0};
    int seq[$];
    bit ok;
    for (int k = 0; k < NREQ; k++) setReq(k, 0, 0, 1'b0);
    bus.adc_tvalid = '1;
    bus.req = '1;
    for (int c = 0; c < 60 && seq.size() < 5; c++) begin
      @(negedge aclk);
      if (bus.grant != '0) begin
        nTotal++;
        if (!$onehot(bus.grant)) $display("[TB] FAIL rr_onehot got %b expected one-hot", bus.grant);
        else nPass++;
        for (int k = 0; k < NREQ; k++) if (bus.grant[k]) seq.push_back(k);
      end
    end
    bus.req = '0;
    nTotal++;
    if (seq.size() != 5) $display("[TB] FAIL rr_count got %0d grants expected 5", seq.size());
    else nPass++;
    for (int i = 0; i < 5 && i < seq.size(); i++) begin
      nTotal++;
      if (seq[i] !== expOrder[i]) $display("[TB] FAIL rr_order[%0d] got %0d expected %0d", i, seq[i], expOrder[i]);
      else nPass++;
    end
    waitIdle(ok);
    nTotal++;
    if (!ok) $display("[TB] FAIL rr_idle got busy=%b expected 0 within bound", bus.busy);
    else nPass++;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] g;
    wr_t e, o;
    setReq(0, 2, 3, 1'b0);
    bus.adc_tvalid = '1;
    bus.req = 4'b0001;
    waitGrant(g);
    nTotal++;
    if (g !== 4'b0001) $display("[TB] FAIL single_grant got %b expected 0001", g);
    else nPass++;
    bus.req = '0;
    setReq(0, 5, 0, 1'b1);
    runWindow(12, '1, 2, 3, -1, -1);
    nTotal++;
    if (obsQ.size() != 4) $display("[TB] FAIL single_count got %0d writes expected 4", obsQ.size());
    else nPass++;
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      nTotal++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc)
        $display("[TB] FAIL single_write got addr=%0d cyc=%0d data=%h expected addr=%0d cyc=%0d data=%h",
                 o.addr, o.cyc, o.data, e.addr, e.cyc, e.data);
      else nPass++;
    end
    nTotal++;
    if (doneCyc !== lastBeatCyc + 2 || doneVal !== 4'b0001)
      $display("[TB] FAIL single_done got cyc=%0d val=%b expected cyc=%0d val=0001", doneCyc, doneVal, lastBeatCyc + 2);
    else nPass++;
    nTotal++;
    if (abortedCyc != -1 || extraGrants != 0)
      $display("[TB] FAIL single_spurious got aborted_cyc=%0d extra_grants=%0d expected -1 and 0", abortedCyc, extraGrants);
    else nPass++;
  endtask

  task automatic test_gapped();
    logic [NREQ-1:0] g;
    wr_t e, o;
    setReq(2, 5, 2, 1'b0);
    bus.req = 4'b0100;
    waitGrant(g);
    nTotal++;
    if (g !== 4'b0100) $display("[TB] FAIL gap_grant got %b expected 0100", g);
    else nPass++;
    bus.req = '0;
    runWindow(12, 64'b11001, 5, 2, -1, -1);
    nTotal++;
    if (obsQ.size() != 3) $display("[TB] FAIL gap_count got %0d writes expected 3", obsQ.size());
    else nPass++;
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      nTotal++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc)
        $display("[TB] FAIL gap_write got addr=%0d cyc=%0d data=%h expected addr=%0d cyc=%0d data=%h",
                 o.addr, o.cyc, o.data, e.addr, e.cyc, e.data);
      else nPass++;
    end
    nTotal++;
    if (doneCyc !== lastBeatCyc + 2 || doneVal !== 4'b0100)
      $display("[TB] FAIL gap_done got cyc=%0d val=%b expected cyc=%0d val=0100", doneCyc, doneVal, lastBeatCyc + 2);
    else nPass++;
  endtask

  task automatic test_sync();
    logic [NREQ-1:0] g;
    wr_t e, o;
    int firstCyc;
    setReq(3, 7, 1, 1'b1);
    bus.sysref_i = 1'b0;
    bus.req = 4'b1000;
    waitGrant(g);
    nTotal++;
    if (g !== 4'b1000) $display("[TB] FAIL sync_grant got %b expected 1000", g);
    else nPass++;
    bus.req = '0;
    runWindow(20, '1, 7, 1, 10, -1);
    firstCyc = (obsQ.size() > 0) ? obsQ[0].cyc : -1;
    nTotal++;
    if (firstCyc != 12) $display("[TB] FAIL sync_first_write got cyc=%0d expected 12", firstCyc);
    else nPass++;
    nTotal++;
    if (obsQ.size() != 2) $display("[TB] FAIL sync_count got %0d writes expected 2", obsQ.size());
    else nPass++;
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      nTotal++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc)
        $display("[TB] FAIL sync_write got addr=%0d cyc=%0d data=%h expected addr=%0d cyc=%0d data=%h",
                 o.addr, o.cyc, o.data, e.addr, e.cyc, e.data);
      else nPass++;
    end
    nTotal++;
    if (doneCyc !== lastBeatCyc + 2 || doneVal !== 4'b1000)
      $display("[TB] FAIL sync_done got cyc=%0d val=%b expected cyc=%0d val=1000", doneCyc, doneVal, lastBeatCyc + 2);
    else nPass++;
  endtask

  task automatic test_abort_last();
    logic [NREQ-1:0] g;
    wr_t e, o;
    bus.abort = 1'b1;
    @(negedge aclk);
    bus.abort = 1'b0;
    nTotal++;
    if (bus.aborted !== 1'b0 || bus.busy !== 1'b0)
      $display("[TB] FAIL abort_idle got aborted=%b busy=%b expected 0 0", bus.aborted, bus.busy);
    else nPass++;
    setReq(1, 1, 1, 1'b0);
    bus.req = 4'b0010;
    waitGrant(g);
    nTotal++;
    if (g !== 4'b0010) $display("[TB] FAIL abort_grant got %b expected 0010", g);
    else nPass++;
    bus.req = '0;
    runWindow(8, '1, 1, 1, -1, 1);
    nTotal++;
    if (obsQ.size() != 2) $display("[TB] FAIL abort_count got %0d writes expected 2", obsQ.size());
    else nPass++;
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      nTotal++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc)
        $display("[TB] FAIL abort_write got addr=%0d cyc=%0d data=%h expected addr=%0d cyc=%0d data=%h",
                 o.addr, o.cyc, o.data, e.addr, e.cyc, e.data);
      else nPass++;
    end
    nTotal++;
    if (abortedCyc != 2 || doneCyc != -1 || busyLog[2] !== 1'b0)
      $display("[TB] FAIL abort_status got aborted_cyc=%0d done_cyc=%0d busy=%b expected 2 -1 0",
               abortedCyc, doneCyc, busyLog[2]);
    else nPass++;
  endtask

  task automatic test_back_to_back();
    int expOrder[3] = '{2, 0, 2};
    int seq[$];
    bit ok;
    setReq(0, 3, 0, 1'b0);
    setReq(2, 3, 0, 1'b0);
    bus.adc_tvalid = '1;
    bus.req = 4'b0101;
    for (int c = 0; c < 40 && seq.size() < 3; c++) begin
      @(negedge aclk);
      for (int k = 0; k < NREQ; k++) if (bus.grant[k]) seq.push_back(k);
    end
    bus.req = '0;
    nTotal++;
    if (seq.size() != 3) $display("[TB] FAIL b2b_count got %0d grants expected 3", seq.size());
    else nPass++;
    for (int i = 0; i < 3 && i < seq.size(); i++) begin
      nTotal++;
      if (seq[i] !== expOrder[i]) $display("[TB] FAIL b2b_order[%0d] got %0d expected %0d", i, seq[i], expOrder[i]);
      else nPass++;
    end
    waitIdle(ok);
    nTotal++;
    if (!ok) $display("[TB] FAIL b2b_idle got busy=%b expected 0 within bound", bus.busy);
    else nPass++;
    bus.adc_tvalid = '0;
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] g;
    bit ok;
    setReq(1, 4, 9, 1'b0);
    bus.adc_tvalid = '1;
    bus.req = 4'b0010;
    waitGrant(g);
    nTotal++;
    if (g !== 4'b0010) $display("[TB] FAIL rst_mid_grant got %b expected 0010", g);
    else nPass++;
    bus.req = '0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge aclk);
      driveData();
    end
    nTotal++;
    if (bus.busy !== 1'b1 || bus.buf_wr_en !== 1'b1)
      $display("[TB] FAIL rst_mid_active got busy=%b wr_en=%b expected 1 1", bus.busy, bus.buf_wr_en);
    else nPass++;
    aresetn = 1'b0;
    #1;
    nTotal++;
    if ({bus.grant, bus.done, bus.aborted, bus.busy, bus.buf_wr_en} !== '0 ||
        bus.buf_wr_addr !== '0 || bus.buf_wr_data !== '0)
      $display("[TB] FAIL rst_mid_outputs got busy=%b wr_en=%b addr=%0d expected all 0",
               bus.busy, bus.buf_wr_en, bus.buf_wr_addr);
    else nPass++;
    @(negedge aclk);
    setReq(1, 0, 0, 1'b0);
    setReq(3, 0, 0, 1'b0);
    bus.req = 4'b1010;
    aresetn = 1'b1;
    waitGrant(g);
    nTotal++;
    if (g !== 4'b0010) $display("[TB] FAIL rst_mid_first_grant got %b expected 0010", g);
    else nPass++;
    bus.req = '0;
    waitIdle(ok);
    nTotal++;
    if (!ok) $display("[TB] FAIL rst_mid_idle got busy=%b expected 0 within bound", bus.busy);
    else nPass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_gapped();
    test_sync();
    test_abort_last();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] run did not complete");
  end
endmodule

// File: doc/adc_snap_sched.md
ADC_SNAP_SCHED -- requirements
Module: adc_snap_sched

Interface
REQ-001 Parameter NREQ, default 4, number of capture requesters.
REQ-002 Parameter NCHAN, default 8, number of ADC AXI4-Stream inputs.
REQ-003 Parameter LEN_W, default 10, capture-length field width (buffer depth 2**LEN_W beats).
REQ-004 aclk  in  1  ADC stream clock; the single clock for all logic.
REQ-005 aresetn  in  1  reset, asynchronous, active-low.
REQ-006 req  in  NREQ  per-requester capture request, level.
REQ-007 req_chan  in  NREQ*3  per-requester channel select, 0..NCHAN-1.
REQ-008 req_len  in  NREQ*LEN_W  per-requester length; L captures L+1 beats.
REQ-009 req_sync  in  NREQ  1 = start only on the next SYSREF rising edge.
REQ-010 abort  in  1  cancel the capture in progress.
REQ-011 adc_tdata  in  NCHAN*128  ADC stream data, channel k at bits [128k+127:128k].
REQ-012 adc_tvalid  in  NCHAN  ADC stream valid; there is no tready.
REQ-013 sysref_i  in  1  SYSREF already registered in the aclk domain.
REQ-014 grant  out  NREQ  one-hot one-cycle pulse when a request is accepted.
REQ-015 done  out  NREQ  one-cycle pulse to the granted requester on completion.
REQ-016 aborted  out  1  one-cycle pulse when an abort takes effect.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 buf_wr_en, buf_wr_addr (LEN_W), buf_wr_data (128)  out  shared capture-buffer write port.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT_SYNC, CAPTURE and DONE.
REQ-020 In IDLE with any req high, the round-robin arbiter SHALL grant in the same cycle, searching upward from (last granted + 1) mod NREQ; the pointer is 0 after reset.
REQ-021 On grant, the block SHALL latch chan, len and sync for the winner, clear the address counter, and go to WAIT_SYNC if sync=1, otherwise to CAPTURE.
REQ-022 WAIT_SYNC SHALL detect the edge sysref_i=1 with previous sysref_i=0, evaluated only from the cycle after grant; CAPTURE begins the cycle after the edge.
REQ-023 In CAPTURE, each cycle with the selected tvalid=1 SHALL be one beat; cycles with tvalid=0 write nothing and do not advance.
REQ-024 Write latency SHALL be 1 cycle: buf_wr_en, buf_wr_data and buf_wr_addr are registered from the sampled beat; the address starts at 0 and increments by 1.
REQ-025 After beat L+1, the FSM SHALL enter DONE for exactly one cycle with done[i]=1, then return to IDLE.
REQ-026 A req still high in IDLE after DONE SHALL be re-arbitrated normally, so back-to-back captures are legal; round-robin order still applies.
REQ-027 abort in WAIT_SYNC or CAPTURE SHALL go to IDLE the next cycle, pulse aborted and give no done; abort in IDLE or DONE SHALL be ignored.
REQ-028 abort coincident with the last beat: abort wins, that beat is still written, and no done is issued.
REQ-029 Changes to req_chan, req_len or req_sync after grant SHALL have no effect on the capture in progress.
REQ-030 An out-of-range channel (>= NCHAN) SHALL be treated as tvalid=0, so the capture waits until aborted.

Reset
REQ-031 While aresetn=0, all outputs SHALL be 0, the FSM SHALL be IDLE and the round-robin pointer SHALL be 0, regardless of the operation in progress.
REQ-032 The first grant SHALL occur no earlier than the second aclk edge after aresetn deasserts.

Structure
REQ-033 Package adc_snap_pkg SHALL hold the state enum, DATA_W=128 and CHAN_W=3.
REQ-034 Arbitration SHALL be one sub-module, rr_arbiter, parameterised on NREQ, with a priority pointer and a one-hot grant.

Verification
REQ-035 Single capture: req[0], chan 2, len 3, sync 0, tvalid 1 continuously -> grant[0] pulse; 4 writes at addresses 0..3 carrying chan-2 data; done[0] pulse 1 cycle after the last write.
REQ-036 Round-robin fairness: req=4'b1111 held -> grant order 0,1,2,3,0.
REQ-037 Sync start: sync 1, SYSREF edge 10 cycles after grant -> first buf_wr_en exactly 2 cycles after the edge cycle; no write before it.
REQ-038 Gapped valid: tvalid pattern 1,0,0,1,1 with len 2 -> 3 writes at consecutive addresses 0..2; done after the third.
REQ-039 Abort on the last beat: len 1, abort with beat 2 -> 2 writes, aborted=1, done stays 0, busy=0 next cycle.
REQ-040 Reset mid-capture: aresetn low during beat 5 -> all outputs 0 immediately; after release with req[1] high, grant[1] is the first grant.
